// File: rtl/edp_op_seq.sv
// ---------------------------------------------------------------------------
// edp_op_seq -- EBOX datapath operand microsequencer
//
// Drives the EDP AR/BR/AD/FM control inputs for a few simple operand
// operations in place of a CRAM word stream. One command at a time is taken
// over a valid/ready handshake; operands are fetched from the cache with a
// request/valid handshake. The EDP controls step one state per eboxClk and
// the sequence ends with a one-cycle done or error pulse.
//
// Commands (cmdOp): 0 LOADAR  AR <- cache
//                   1 ADD     AR <- cache1 + cache2, carry captured
//                   2 FMWR    FM[blk,ac] <- AD (AR)
//                   3 illegal -> error pulse
//
// Ports
//   eboxClk, eboxReset_n      clock, async active-low reset
//   cmdValid/cmdReady         command handshake; cmdOp/cmdAC/cmdBlk payload
//   cacheReq/cacheValid       operand fetch handshake
//   EDP_ADcarry0              adder carry from the EDP, sampled at end of SUM
//   busy, done, error         status; done/error are one-cycle pulses
//   resultCarry               carry of the most recent ADD
//   CRAM_*, CTL_*, APR_*, CON_*  EDP controls, Moore-decoded from state
//
// Build option
//   EDP_SEQ_TIMEOUT_EN  when defined, a 4-bit wait counter aborts a cache
//                       wait to the error state after TIMEOUT cycles.
// ---------------------------------------------------------------------------
module edp_op_seq #(
  parameter logic [6:0] AD_A        = 7'o37,
  parameter logic [6:0] AD_APLUSB   = 7'o06,
  parameter logic [3:0] ADA_AR      = 4'd0,
  parameter logic [2:0] ADB_BR      = 3'd2,
  parameter logic [2:0] ARSEL_CACHE = 3'd1,
  parameter logic [2:0] ARSEL_AD    = 3'd2
`ifdef EDP_SEQ_TIMEOUT_EN
  ,
  parameter int         TIMEOUT     = 15
`endif
) (
  input  logic       eboxClk,
  input  logic       eboxReset_n,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdOp,
  input  logic [3:0] cmdAC,
  input  logic [2:0] cmdBlk,
  output logic       cacheReq,
  input  logic       cacheValid,
  input  logic       EDP_ADcarry0,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       resultCarry,
  output logic [6:0] CRAM_AD,
  output logic [3:0] CRAM_ADA,
  output logic [1:0] CRAM_ADA_EN,
  output logic [2:0] CRAM_ADB,
  output logic [2:0] CTL_ARL_SEL,
  output logic [2:0] CTL_ARR_SEL,
  output logic       CTL_AR00to08load,
  output logic       CTL_AR09to17load,
  output logic       CTL_ARRload,
  output logic       CRAM_BRload,
  output logic [2:0] APR_FMblk,
  output logic [3:0] APR_FMadr,
  output logic       CON_fmWrite00_17,
  output logic       CON_fmWrite18_35
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WAITC = 4'd1;
  localparam logic [3:0] S_LDAR1 = 4'd2;
  localparam logic [3:0] S_XFER  = 4'd3;
  localparam logic [3:0] S_LDAR2 = 4'd4;
  localparam logic [3:0] S_SUM   = 4'd5;
  localparam logic [3:0] S_FMW   = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam logic [1:0] OP_LOADAR = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_FMWR   = 2'd2;

  logic [3:0] state_q, state_d;
  logic [1:0] op_q;
  logic [3:0] ac_q;
  logic [2:0] blk_q;
  logic       opnd2_q, opnd2_d;   // set once the ADD's first operand is in BR
  logic       carry_q;
  logic       accept;

  assign accept = cmdValid && (state_q == S_IDLE);

`ifdef EDP_SEQ_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       wait_expired;

  // cnt_q counts completed WAITC cycles; it equals TIMEOUT-1 during the
  // TIMEOUT-th cycle, which is the last chance for cacheValid.
  assign wait_expired = (cnt_q == 4'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WAITC && !cacheValid) cnt_d = cnt_q + 4'd1;
    if (state_d == S_WAITC && state_q != S_WAITC) cnt_d = 4'd0;
  end

  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) cnt_q <= 4'd0;
    else              cnt_q <= cnt_d;
  end
`endif

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opnd2_d = opnd2_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opnd2_d = 1'b0;
          case (cmdOp)
            OP_LOADAR, OP_ADD: state_d = S_WAITC;
            OP_FMWR:           state_d = S_FMW;
            default:           state_d = S_ERR;
          endcase
        end
      end
      S_WAITC: begin
        // cacheValid takes priority over an expiring wait
        if (cacheValid)        state_d = opnd2_q ? S_LDAR2 : S_LDAR1;
`ifdef EDP_SEQ_TIMEOUT_EN
        else if (wait_expired) state_d = S_ERR;
`endif
      end
      S_LDAR1: state_d = (op_q == OP_ADD) ? S_XFER : S_DONE;
      S_XFER: begin
        state_d = S_WAITC;
        opnd2_d = 1'b1;
      end
      S_LDAR2: state_d = S_SUM;
      S_SUM:   state_d = S_DONE;
      S_FMW:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and command registers
  // -------------------------------------------------------------------------
  always_ff @(posedge eboxClk or negedge eboxReset_n) begin
    if (!eboxReset_n) begin
      state_q <= S_IDLE;
      opnd2_q <= 1'b0;
      op_q    <= 2'd0;
      ac_q    <= 4'd0;
      blk_q   <= 3'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd2_q <= opnd2_d;
      if (accept) begin
        op_q  <= cmdOp;
        ac_q  <= cmdAC;
        blk_q <= cmdBlk;
      end
      // The EDP adder output is valid for A+B at the edge that ends SUM
      if (state_q == S_SUM) carry_q <= EDP_ADcarry0;
    end
  end

  assign resultCarry = carry_q;
  assign CRAM_ADA_EN = 2'b00;

  // -------------------------------------------------------------------------
  // Moore decode of EDP controls; all-zero means AR recirculates, no loads
  // -------------------------------------------------------------------------
  always_comb begin
    cmdReady         = (state_q == S_IDLE);
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_DONE);
    error            = (state_q == S_ERR);
    cacheReq         = (state_q == S_WAITC);
    CRAM_AD          = 7'd0;
    CRAM_ADA         = 4'd0;
    CRAM_ADB         = 3'd0;
    CTL_ARL_SEL      = 3'd0;
    CTL_ARR_SEL      = 3'd0;
    CTL_AR00to08load = 1'b0;
    CTL_AR09to17load = 1'b0;
    CTL_ARRload      = 1'b0;
    CRAM_BRload      = 1'b0;
    APR_FMblk        = 3'd0;
    APR_FMadr        = 4'd0;
    CON_fmWrite00_17 = 1'b0;
    CON_fmWrite18_35 = 1'b0;
    case (state_q)
      S_LDAR1, S_LDAR2: begin
        CTL_ARL_SEL      = ARSEL_CACHE;
        CTL_ARR_SEL      = ARSEL_CACHE;
        CTL_AR00to08load = 1'b1;
        CTL_AR09to17load = 1'b1;
        CTL_ARRload      = 1'b1;
      end
      S_XFER: begin
        // BR <- AD, with AD passing AR straight through
        CRAM_AD     = AD_A;
        CRAM_ADA    = ADA_AR;
        CRAM_BRload = 1'b1;
      end
      S_SUM: begin
        CRAM_AD          = AD_APLUSB;
        CRAM_ADA         = ADA_AR;
        CRAM_ADB         = ADB_BR;
        CTL_ARL_SEL      = ARSEL_AD;
        CTL_ARR_SEL      = ARSEL_AD;
        CTL_AR00to08load = 1'b1;
        CTL_AR09to17load = 1'b1;
        CTL_ARRload      = 1'b1;
      end
      S_FMW: begin
        CRAM_AD          = AD_A;
        APR_FMblk        = blk_q;
        APR_FMadr        = ac_q;
        CON_fmWrite00_17 = 1'b1;
        CON_fmWrite18_35 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
